mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL have the ports `clk` (input, 1 bit, rising-edge clock) and `reset` (input, 1 bit); there is one clock, and `reset` is asynchronous and active-high.
REQ-002 The block SHALL have the port `inValid` (input, 1): an operation is presented this cycle.
REQ-003 The block SHALL have the port `op` (input, 3): 000 none, 001 LW, 010 SW, 011 LM, 100 SM; any other code is treated as none.
REQ-004 The block SHALL have the port `addr` (input, 16): effective or base address from the ALU.
REQ-005 The block SHALL have the port `storeData` (input, 16): SW data.
REQ-006 The block SHALL have the port `regMask` (input, 8): LM/SM register mask; bit i selects Ri.
REQ-007 The block SHALL have the ports `smRegIdx` (output, 3) and `smRegData` (input, 16): register-file read port used by SM, where `smRegData` is valid in the same cycle as `smRegIdx`.
REQ-008 The block SHALL have the memory ports `memAddr` (output, 16), `memWData` (output, 16), `memRead` (output, 1), `memWrite` (output, 1), `memReady` (input, 1) and `memRData` (input, 16).
REQ-009 The block SHALL have the port `MemData` (output, 16, registered): last loaded word, consumed by the write-back mux.
REQ-010 The block SHALL have the port `outValid` (output, 1, registered): one-cycle operation-complete pulse.
REQ-011 The block SHALL have the ports `lmWrite` (output, 1, registered) and `lmRegIdx` (output, 3, registered): per-word register write strobe and destination for LM.
REQ-012 The block SHALL have the port `busy` (output, 1): the block is not in IDLE; upstream holds its inputs while this is high.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SINGLE and MULTI.
REQ-014 In IDLE, `busy`=0; when `inValid`=1, the block SHALL latch `op`, `addr`, `storeData` and `regMask` on the clock edge.
REQ-015 From IDLE, an accepted none, or an LM/SM with `regMask`=0, SHALL stay in IDLE and pulse `outValid` in the next cycle with no memory access.
REQ-016 From IDLE, an accepted LW or SW SHALL go to SINGLE; an accepted LM or SM with a nonzero mask SHALL go to MULTI with a 16-bit offset counter cleared to 0.
REQ-017 `inValid` SHALL be ignored while `busy`=1.
REQ-018 In SINGLE, `memAddr` SHALL equal the latched address and `memRead`/`memWrite` SHALL be asserted for LW/SW respectively, with `memWData` equal to the latched `storeData`.
REQ-019 The request SHALL be held stable until a cycle with `memReady`=1; on that edge an LW SHALL load `memRData` into `MemData`, and the block SHALL pulse `outValid` and return to IDLE.
REQ-020 In MULTI, the current register SHALL be the lowest-numbered set bit of the remaining mask, and `memAddr` SHALL equal latched base + counter, modulo 2^16 (0xFFFF + 1 wraps to 0x0000).
REQ-021 For SM in MULTI, `memWrite`=1, `smRegIdx`=current register and `memWData`=`smRegData`; this combinational path is permitted.
REQ-022 For LM in MULTI, `memRead`=1, and on each `memReady` edge the block SHALL load `MemData`<=`memRData`, `lmRegIdx`<=current register, and pulse `lmWrite` for one cycle.
REQ-023 On each `memReady` edge in MULTI, the block SHALL clear the current mask bit and increment the counter.
REQ-024 If the clear in REQ-023 empties the mask, the block SHALL pulse `outValid` (coincident with the final `lmWrite` for LM) and return to IDLE.
REQ-025 `memReady` SHALL be ignored when neither `memRead` nor `memWrite` is asserted.
REQ-026 `memRead` and `memWrite` SHALL never be high together and SHALL be driven only from state registers, never from `memReady`.
REQ-027 `smRegIdx` SHALL be 0 outside SM MULTI, and `memAddr`/`memWData` SHALL be 0 in IDLE.
REQ-028 Minimum LW latency SHALL be: accept at edge T, request in cycle T+1, `memReady`=1 in T+1, `MemData`/`outValid` visible in T+2.
REQ-029 Minimum LM/SM throughput SHALL be one word per cycle when `memReady` is held at 1.
REQ-030 SW, SM and none operations SHALL leave `MemData` unchanged.

Reset
REQ-031 While `reset`=1 the block SHALL immediately (asynchronously) enter IDLE, clear the latched operands, mask and counter, and drive `MemData`=0, `outValid`=0, `lmWrite`=0, `lmRegIdx`=0, `memRead`=0, `memWrite`=0, `busy`=0, `memAddr`=0, `memWData`=0 and `smRegIdx`=0.
REQ-032 Reset asserted mid-operation SHALL abort the transfer with no `outValid` pulse, and the first operation after deassertion SHALL behave as if from power-up.

Verification
REQ-033 The bench SHALL cover LW with `addr`=0x1234 and memory returning 0xBEEF after 3 wait cycles -> `memRead`=1 with `memAddr`=0x1234 for 3 cycles, then `MemData`=0xBEEF and a single `outValid` pulse, with `busy` deasserting in the same cycle.
REQ-034 The bench SHALL cover SW with `addr`=0x0040, `storeData`=0x00A5 and `memReady` tied to 1 -> exactly one cycle of `memWrite`=1 at 0x0040 with `memWData`=0x00A5, `outValid` the next cycle, and `MemData` unchanged.
REQ-035 The bench SHALL cover LM with `regMask`=0x85, base 0xFFFE, `memReady`=1 and memory returning 0x1111/0x2222/0x3333 -> addresses 0xFFFE, 0xFFFF, 0x0000; `lmWrite` pulses with `lmRegIdx` 0, 2, 7; `outValid` with the third pulse.
REQ-036 The bench SHALL cover SM with `regMask`=0x0A, base 0x0100, and the register model returning 16'h00<idx>0 -> `smRegIdx` 1 then 3; writes 0x0010@0x0100 and 0x0030@0x0101.
REQ-037 The bench SHALL cover LM with `regMask`=0x00 -> no memory strobes, `outValid` pulse in the next cycle, `busy` never high.
REQ-038 The bench SHALL cover `reset` asserted during the second word of LM with `regMask`=0xFF -> strobes drop in the same cycle, no `outValid`; after release, an LW to 0x0005 returning 0x0007 completes normally.

Source files
------------

// File: rtl/mem_access.sv
// Load/store unit for LW/SW and multi-register LM/SM transfers.
// One memory request per cycle; upstream holds its inputs while busy is high.
module mem_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        inValid,
    input  logic [2:0]  op,
    input  logic [15:0] addr,
    input  logic [15:0] storeData,
    input  logic [7:0]  regMask,
    output logic [2:0]  smRegIdx,
    input  logic [15:0] smRegData,
    output logic [15:0] memAddr,
    output logic [15:0] memWData,
    output logic        memRead,
    output logic        memWrite,
    input  logic        memReady,
    input  logic [15:0] memRData,
    output logic [15:0] MemData,
    output logic        outValid,
    output logic        lmWrite,
    output logic [2:0]  lmRegIdx,
    output logic        busy
);
    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_LW   = 3'd1;
    localparam logic [2:0] OP_SW   = 3'd2;
    localparam logic [2:0] OP_LM   = 3'd3;
    localparam logic [2:0] OP_SM   = 3'd4;

    typedef enum logic [1:0] {IDLE, SINGLE, MULTI} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic [15:0] r_addr;
    logic [15:0] r_sdata;
    logic [7:0]  r_mask;
    logic [15:0] r_cnt;
    logic [15:0] r_memdata;
    logic        r_outvalid;
    logic        r_lmwrite;
    logic [2:0]  r_lmidx;

    logic [2:0]  w_op_in;
    logic [2:0]  w_cur;
    logic [7:0]  w_mask_nxt;
    logic        w_mask_in_zero;

    // Unknown opcodes collapse to none so they complete like a no-op.
    assign w_op_in        = (op > OP_SM) ? OP_NONE : op;
    assign w_mask_in_zero = (regMask == 8'd0);

    // Lowest set bit of the remaining mask is the register served this cycle.
    always_comb begin
        w_cur = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_mask[i]) w_cur = 3'(i);
        end
    end

    assign w_mask_nxt = r_mask & ~(8'd1 << w_cur);

    assign busy     = (r_state != IDLE);
    assign MemData  = r_memdata;
    assign outValid = r_outvalid;
    assign lmWrite  = r_lmwrite;
    assign lmRegIdx = r_lmidx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Strobes depend only on state and latched op; memReady only steers w_next.
    always_comb begin
        w_next   = r_state;
        memAddr  = 16'd0;
        memWData = 16'd0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        smRegIdx = 3'd0;
        case (r_state)
            IDLE: begin
                if (inValid) begin
                    if (w_op_in == OP_LW || w_op_in == OP_SW)
                        w_next = SINGLE;
                    else if ((w_op_in == OP_LM || w_op_in == OP_SM) && !w_mask_in_zero)
                        w_next = MULTI;
                end
            end
            SINGLE: begin
                memAddr  = r_addr;
                memRead  = (r_op == OP_LW);
                memWrite = (r_op == OP_SW);
                if (r_op == OP_SW) memWData = r_sdata;
                if (memReady) w_next = IDLE;
            end
            MULTI: begin
                memAddr  = r_addr + r_cnt;
                memRead  = (r_op == OP_LM);
                memWrite = (r_op == OP_SM);
                if (r_op == OP_SM) begin
                    smRegIdx = w_cur;
                    memWData = smRegData;
                end
                if (memReady && w_mask_nxt == 8'd0) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op       <= OP_NONE;
            r_addr     <= 16'd0;
            r_sdata    <= 16'd0;
            r_mask     <= 8'd0;
            r_cnt      <= 16'd0;
            r_memdata  <= 16'd0;
            r_outvalid <= 1'b0;
            r_lmwrite  <= 1'b0;
            r_lmidx    <= 3'd0;
        end else begin
            r_outvalid <= 1'b0;
            r_lmwrite  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (inValid) begin
                        r_op    <= w_op_in;
                        r_addr  <= addr;
                        r_sdata <= storeData;
                        r_mask  <= regMask;
                        r_cnt   <= 16'd0;
                        if (w_op_in == OP_NONE ||
                            ((w_op_in == OP_LM || w_op_in == OP_SM) && w_mask_in_zero))
                            r_outvalid <= 1'b1;
                    end
                end
                SINGLE: begin
                    if (memReady) begin
                        if (r_op == OP_LW) r_memdata <= memRData;
                        r_outvalid <= 1'b1;
                    end
                end
                MULTI: begin
                    if (memReady) begin
                        r_mask <= w_mask_nxt;
                        r_cnt  <= r_cnt + 16'd1;
                        if (r_op == OP_LM) begin
                            r_memdata <= memRData;
                            r_lmidx   <= w_cur;
                            r_lmwrite <= 1'b1;
                        end
                        if (w_mask_nxt == 8'd0) r_outvalid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: LW/SW/LM/SM, empty mask, bad opcode, mid-transfer reset.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic [2:0]  op;
    logic [15:0] addr, storeData;
    logic [7:0]  regMask;
    logic [2:0]  smRegIdx;
    logic [15:0] smRegData;
    logic [15:0] memAddr, memWData;
    logic        memRead, memWrite, memReady;
    logic [15:0] memRData;
    logic [15:0] MemData;
    logic        outValid, lmWrite, busy;
    logic [2:0]  lmRegIdx;

    int n_cmp = 0;
    int n_err = 0;

    mem_access dut (
        .clk(clk), .reset(reset), .inValid(inValid), .op(op), .addr(addr),
        .storeData(storeData), .regMask(regMask), .smRegIdx(smRegIdx),
        .smRegData(smRegData), .memAddr(memAddr), .memWData(memWData),
        .memRead(memRead), .memWrite(memWrite), .memReady(memReady),
        .memRData(memRData), .MemData(MemData), .outValid(outValid),
        .lmWrite(lmWrite), .lmRegIdx(lmRegIdx), .busy(busy)
    );

    always #5 clk = ~clk;

    // Register-file model: Ri reads as 16'h00i0.
    assign smRegData = {8'h00, 1'b0, smRegIdx, 4'h0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; inValid = 1'b0; op = 3'd0; addr = 16'd0;
        storeData = 16'd0; regMask = 8'd0; memReady = 1'b0; memRData = 16'd0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_memdata", MemData, 16'h0);
        chk("rst_strobes", {memRead, memWrite, outValid, lmWrite}, 4'b0000);
        chk("rst_addr", memAddr, 16'h0);
        tick(); tick();
        reset = 1'b0;

        // LW 0x1234, three wait cycles, then 0xBEEF; inValid during busy is ignored
        inValid = 1'b1; op = 3'd1; addr = 16'h1234;
        #1 chk("lw_idle_busy", busy, 0);
        tick();
        op = 3'd2; addr = 16'h9999; storeData = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_wait_rd", {busy, memRead, memWrite}, 3'b110);
            chk("lw_wait_addr", memAddr, 16'h1234);
            tick();
        end
        inValid = 1'b0;
        memReady = 1'b1; memRData = 16'hBEEF;
        #1 chk("lw_ready_rd", memRead, 1);
        tick();
        memReady = 1'b0; memRData = 16'h0;
        #1;
        chk("lw_memdata", MemData, 16'hBEEF);
        chk("lw_done", {outValid, busy, memRead}, 3'b100);
        tick();
        chk("lw_pulse_end", outValid, 0);
        chk("lw_no_extra_op", busy, 0);

        // SW 0x00A5 @ 0x0040, memReady tied high
        memReady = 1'b1;
        inValid = 1'b1; op = 3'd2; addr = 16'h0040; storeData = 16'h00A5;
        tick();
        inValid = 1'b0;
        #1;
        chk("sw_strobe", {memWrite, memRead}, 2'b10);
        chk("sw_addr", memAddr, 16'h0040);
        chk("sw_wdata", memWData, 16'h00A5);
        chk("sw_no_ov_yet", outValid, 0);
        tick();
        chk("sw_done", {outValid, memWrite, busy}, 3'b100);
        chk("sw_memdata_kept", MemData, 16'hBEEF);
        chk("sw_idle_wdata", memWData, 16'h0);

        // LM mask 0x85 from 0xFFFE, address wraps
        inValid = 1'b1; op = 3'd3; addr = 16'hFFFE; regMask = 8'h85;
        tick();
        inValid = 1'b0; memRData = 16'h1111;
        #1;
        chk("lm0_addr", memAddr, 16'hFFFE);
        chk("lm0_rd", {memRead, memWrite}, 2'b10);
        tick();
        memRData = 16'h2222;
        #1;
        chk("lm1_wr", {lmWrite, lmRegIdx, outValid}, {1'b1, 3'd0, 1'b0});
        chk("lm1_data", MemData, 16'h1111);
        chk("lm1_addr", memAddr, 16'hFFFF);
        tick();
        memRData = 16'h3333;
        #1;
        chk("lm2_wr", {lmWrite, lmRegIdx, outValid}, {1'b1, 3'd2, 1'b0});
        chk("lm2_data", MemData, 16'h2222);
        chk("lm2_addr", memAddr, 16'h0000);
        tick();
        chk("lm3_wr", {lmWrite, lmRegIdx, outValid}, {1'b1, 3'd7, 1'b1});
        chk("lm3_data", MemData, 16'h3333);
        chk("lm3_idle", {busy, memRead}, 2'b00);
        tick();
        chk("lm_pulse_end", {lmWrite, outValid}, 2'b00);

        // SM mask 0x0A from 0x0100
        inValid = 1'b1; op = 3'd4; addr = 16'h0100; regMask = 8'h0A;
        #1 chk("sm_idle_idx", smRegIdx, 3'd0);
        tick();
        inValid = 1'b0;
        #1;
        chk("sm0_idx", smRegIdx, 3'd1);
        chk("sm0_wr", {memWrite, memRead}, 2'b10);
        chk("sm0_addr_data", {memAddr, memWData}, {16'h0100, 16'h0010});
        tick();
        chk("sm1_idx", smRegIdx, 3'd3);
        chk("sm1_addr_data", {memAddr, memWData}, {16'h0101, 16'h0030});
        chk("sm1_no_ov", outValid, 0);
        tick();
        chk("sm_done", {outValid, memWrite, busy, lmWrite}, 4'b1000);
        chk("sm_idx_clr", smRegIdx, 3'd0);
        chk("sm_memdata_kept", MemData, 16'h3333);

        // LM with empty mask: immediate completion, no access
        inValid = 1'b1; op = 3'd3; addr = 16'h0200; regMask = 8'h00;
        tick();
        inValid = 1'b0;
        chk("lm0m_done", {outValid, busy, memRead, memWrite}, 4'b1000);
        tick();
        chk("lm0m_after", {outValid, busy}, 2'b00);

        // Undefined opcode acts as none
        inValid = 1'b1; op = 3'd7; addr = 16'h0300; regMask = 8'hFF;
        tick();
        inValid = 1'b0;
        chk("badop_done", {outValid, busy, memRead, memWrite}, 4'b1000);
        chk("badop_memdata", MemData, 16'h3333);

        // Reset during second word of LM 0xFF
        inValid = 1'b1; op = 3'd3; addr = 16'h0200; regMask = 8'hFF; memRData = 16'hAAAA;
        tick();
        inValid = 1'b0;
        tick();
        chk("rlm_word1", {memRead, memAddr}, {1'b1, 16'h0201});
        chk("rlm_lmw", lmWrite, 1);
        reset = 1'b1;
        #1;
        chk("rlm_async", {memRead, busy, lmWrite, outValid}, 4'b0000);
        chk("rlm_clr", {memAddr, MemData}, 32'h0);
        tick();
        chk("rlm_no_ov", outValid, 0);
        reset = 1'b0;
        memRData = 16'h0007;
        inValid = 1'b1; op = 3'd1; addr = 16'h0005;
        tick();
        inValid = 1'b0;
        #1 chk("post_lw_req", {memRead, memAddr}, {1'b1, 16'h0005});
        tick();
        chk("post_lw_done", {outValid, busy, MemData}, {1'b1, 1'b0, 16'h0007});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
